// File: rtl/lsu_byte_lane.sv
// Load/store unit for the memory-access stage: owns a byte-enabled synchronous RAM,
// steers byte/half/word lanes from the address offset and answers every access once.
module lsu_byte_lane #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_load,
    input  logic            req_is_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_dstreg,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [4:0]      rsp_dstreg,
    output logic            rsp_is_load,
    output logic            rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [XLEN-1:0] mem_r [DEPTH_WORDS];
    logic [XLEN-1:0] rd_data_r;

    logic [XLEN-1:0] rel_addr_s;
    logic [AW-1:0]   word_idx_s;
    logic [1:0]      offset_s;
    logic            in_range_s;
    logic            fault_s;
    logic            accept_s;
    logic            access_s;
    logic            wr_en_s;
    logic            rd_en_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_rep_s;

    logic [1:0]      off_r;
    logic [1:0]      size_r;
    logic            uns_r;
    logic [4:0]      dstreg_r;
    logic            is_load_r;
    logic            fault_r;

    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] load_data_s;

    // Request decode: word index, range/alignment faults, lane enables and replicated write data.
    always_comb begin
        rel_addr_s  = req_addr - BASE_ADDR;
        word_idx_s  = rel_addr_s[AW+1:2];
        offset_s    = rel_addr_s[1:0];
        // Addresses below BASE_ADDR wrap to huge offsets and fail this test too.
        in_range_s  = (rel_addr_s[XLEN-1:AW+2] == {(XLEN-AW-2){1'b0}});
        fault_s     = 1'b0;
        be_s        = 4'b0000;
        wdata_rep_s = {XLEN{1'b0}};
        case (req_size)
            SZ_BYTE: begin
                be_s        = 4'b0001 << offset_s;
                wdata_rep_s = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_s        = 4'b0011 << offset_s;
                wdata_rep_s = {2{req_wdata[15:0]}};
                if (offset_s[0] != 1'b0) begin
                    fault_s = 1'b1;
                end else begin
                    fault_s = 1'b0;
                end
            end
            SZ_WORD: begin
                be_s        = 4'b1111;
                wdata_rep_s = req_wdata;
                if (offset_s != 2'b00) begin
                    fault_s = 1'b1;
                end else begin
                    fault_s = 1'b0;
                end
            end
            default: begin
                fault_s = 1'b1;
            end
        endcase
        if (!in_range_s || (req_is_load && req_is_store)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_s;
        end
    end

    // Handshake qualifiers; an access with neither load nor store is swallowed without response.
    always_comb begin
        accept_s = req_valid && (state_r == ST_IDLE);
        access_s = accept_s && (req_is_load || req_is_store);
        wr_en_s  = access_s && req_is_store && !fault_s;
        rd_en_s  = access_s && req_is_load && !fault_s;
    end

    // Byte-enabled RAM write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[word_idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
                end
            end
        end
    end

    // RAM output register: loaded only on a load accept, held throughout RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {XLEN{1'b0}};
        end else if (rd_en_s) begin
            rd_data_r <= mem_r[word_idx_s];
        end
    end

    // Per-access attributes captured at accept and held while the response waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_r     <= 2'b00;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            dstreg_r  <= 5'd0;
            is_load_r <= 1'b0;
            fault_r   <= 1'b0;
        end else if (access_s) begin
            off_r     <= offset_s;
            size_r    <= req_size;
            uns_r     <= req_unsigned;
            dstreg_r  <= req_dstreg;
            is_load_r <= req_is_load;
            fault_r   <= fault_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: one response per access, held until the consumer takes it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Load alignment and extension from the held RAM word.
    always_comb begin
        shifted_s   = rd_data_r >> {off_r, 3'b000};
        load_data_s = {XLEN{1'b0}};
        case (size_r)
            SZ_BYTE: begin
                if (uns_r) begin
                    load_data_s = {24'd0, shifted_s[7:0]};
                end else begin
                    load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_HALF: begin
                if (uns_r) begin
                    load_data_s = {16'd0, shifted_s[15:0]};
                end else begin
                    load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_WORD: begin
                load_data_s = shifted_s;
            end
            default: begin
                load_data_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Output drive; read data is forced to zero outside a successful load response.
    always_comb begin
        req_ready   = (state_r == ST_IDLE);
        rsp_valid   = (state_r == ST_RESP);
        rsp_dstreg  = dstreg_r;
        rsp_is_load = is_load_r;
        rsp_fault   = fault_r;
        if (rsp_valid && is_load_r && !fault_r) begin
            rsp_rdata = load_data_s;
        end else begin
            rsp_rdata = {XLEN{1'b0}};
        end
    end

    lsu_byte_lane_chk #(.XLEN(XLEN)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_dstreg (rsp_dstreg),
        .rsp_is_load(rsp_is_load),
        .rsp_fault  (rsp_fault)
    );

endmodule

// Protocol properties of the response channel.
module lsu_byte_lane_chk #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst_n,
    input logic            req_ready,
    input logic            rsp_valid,
    input logic            rsp_ready,
    input logic [XLEN-1:0] rsp_rdata,
    input logic [4:0]      rsp_dstreg,
    input logic            rsp_is_load,
    input logic            rsp_fault
);

    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        req_ready != rsp_valid);

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_dstreg)
                                       && $stable(rsp_is_load) && $stable(rsp_fault)));

    a_fault_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && rsp_fault) |-> (rsp_rdata == {XLEN{1'b0}}));

endmodule

// File: tb/tb_lsu_byte_lane.sv
// Table-driven bench for lsu_byte_lane with a response scoreboard and hand-written
// sequences for back-pressure and mid-response reset.
module tb_lsu_byte_lane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_load, req_is_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_dstreg;
    logic        rsp_valid, rsp_ready, rsp_is_load, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_dstreg;

    lsu_byte_lane #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dstreg(req_dstreg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_dstreg(rsp_dstreg), .rsp_is_load(rsp_is_load), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ld;
        bit        st;
        bit [1:0]  sz;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_fault;
        bit        chk_ld;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        is_load;
        logic        chk_ld;
        logic [4:0]  dst;
    } exp_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit ld, input bit st, input bit [1:0] sz, input bit uns,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                input bit [31:0] exp_rdata, input bit exp_fault, input bit chk_ld);
        vec_t v;
        v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.chk_ld = chk_ld;
        return v;
    endfunction

    // Scoreboard: a response is compared on the cycle its handshake completes.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rsp: got response dst %0d, want none", rsp_dstreg);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, mon_e.fault});
                chk("rsp_dstreg", {27'd0, rsp_dstreg}, {27'd0, mon_e.dst});
                if (mon_e.chk_ld) chk("rsp_is_load", {31'd0, rsp_is_load}, {31'd0, mon_e.is_load});
            end
        end
    end

    task automatic drive(input vec_t v, input logic [4:0] dst);
        req_valid    = 1'b1;
        req_is_load  = v.ld;
        req_is_store = v.st;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_dstreg   = dst;
    endtask

    task automatic push_exp(input vec_t v, input logic [4:0] dst);
        exp_t e;
        e.rdata = v.exp_rdata; e.fault = v.exp_fault; e.is_load = v.ld; e.chk_ld = v.chk_ld; e.dst = dst;
        sb_q.push_back(e);
    endtask

    task automatic apply(input vec_t v, input logic [4:0] dst);
        @(negedge clk);
        drive(v, dst);
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        if (v.ld || v.st) push_exp(v, dst);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_latency", {31'd0, rsp_valid}, {31'd0, (v.ld || v.st)});
        @(negedge clk);
        chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    vec_t hv;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_dstreg = 5'd0;

        //    ld    st    sz    uns   addr          wdata          exp_rdata      flt   chk_ld
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0000_0000, 32'h0000_00BE, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_BEEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0000_0000, 32'h0000_DEAD, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h1234_5680, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h80AD_BEEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hCAFE_8001, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_0000, 32'hFFFF_8001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0000_0000, 32'h0000_8001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h8001_0000, 1'b0, 1'b1));
        // Faults: misaligned, illegal size, both kinds, out of range; then memory untouched.
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1000, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0014, 32'h7777_7777, 32'h0000_0000, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h9999_9999, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h80AD_BEEF, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 1'b0, 1'b1));
        // Last word of the RAM.
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0123_4567, 32'h0000_0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h0123_4567, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0FFE, 32'h0000_0000, 32'h0000_0123, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0FFD, 32'h0000_0000, 32'h0000_0045, 1'b0, 1'b1));

        #12;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_dstreg", {27'd0, rsp_dstreg}, 32'd0);
        chk("reset_rsp_is_load", {31'd0, rsp_is_load}, 32'd0);
        chk("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 5'((i % 31) + 1));
        end

        // Back-pressure: LB 0x13 held for 5 cycles while a store tries to get in.
        hv = mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(hv, 5'd7);
        push_exp(hv, 5'd7);
        @(posedge clk);
        #1 drive(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h5555_5555, 32'h0, 1'b0, 1'b1), 5'd8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
            chk("hold_rsp_dstreg", {27'd0, rsp_dstreg}, 32'd7);
            chk("hold_rsp_is_load", {31'd0, rsp_is_load}, 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("release_cleared", {31'd0, rsp_valid}, 32'd0);
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        apply(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b1), 5'd10);

        // Asynchronous reset while a load response is pending.
        hv = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(hv, 5'd9);
        push_exp(hv, 5'd9);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("prereset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_req_ready", {31'd0, req_ready}, 32'd1);
        chk("async_rsp_dstreg", {27'd0, rsp_dstreg}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("postreset_req_ready", {31'd0, req_ready}, 32'd1);
        apply(hv, 5'd11);

        chk("final_sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
